activation_function: RTL and testbench
======================================

ACTIVATION_FUNCTION -- requirements
Module: activation_function

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32, the width of one IEEE-754 single-precision lane.
REQ-002 The module SHALL have parameter OUTPUT_NODES, default 32, the number of lanes.
REQ-003 The module SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit, reset; one clock, reset synchronous and active-high.
REQ-005 The module SHALL have port en, input, 1 bit, capture enable.
REQ-006 The module SHALL have port input_fc, input, DATA_WIDTH*OUTPUT_NODES bits, packed lanes; lane i is bits [DATA_WIDTH*i +: DATA_WIDTH].
REQ-007 The module SHALL have port output_fc, output, DATA_WIDTH*OUTPUT_NODES bits, registered packed results with the same lane mapping.

Function
REQ-008 Each lane SHALL apply ReLU: sign bit (MSB) = 1 gives all-zero; sign bit = 0 passes the word unchanged.
REQ-009 Negative zero 0x80000000 SHALL produce +0.0 (0x00000000); +0.0 passes as 0x00000000.
REQ-010 Negative infinity and negative NaN SHALL produce 0x00000000; +inf (0x7F800000) and positive denormals SHALL pass unchanged.
REQ-011 Lanes SHALL be independent, with no cross-lane interaction.
REQ-012 Latency SHALL be one clock: with en=1 at rising edge k, output_fc after edge k reflects input_fc sampled at edge k.
REQ-013 With en=0 and reset=0, output_fc SHALL hold its previous value.
REQ-014 There SHALL be no handshake or state machine; the block is a purely registered datapath.
REQ-015 output_fc SHALL depend only on registered state, with no combinational input-to-output path.

Reset
REQ-016 reset=1 at a rising edge SHALL clear every output lane to 0x00000000, regardless of en or input_fc.
REQ-017 reset SHALL take priority over en when both are asserted in the same cycle.
REQ-018 Reset asserted mid-stream SHALL discard the value captured in that cycle; the first valid capture follows the first edge with reset=0 and en=1.

Configuration
REQ-019 Macro ACT_NAN_FLUSH_EN, when defined, SHALL make any positive NaN lane (exponent 0xFF, mantissa ≠ 0, sign 0) output 0x00000000.
REQ-020 Without ACT_NAN_FLUSH_EN, positive NaN SHALL pass unchanged per REQ-008.
REQ-021 Port list, latency and all non-NaN behaviour SHALL be identical with and without the macro.

Structure
REQ-022 The shared package SHALL hold the FP32 field constants: SIGN_BIT=31, EXP_MSB=30, EXP_LSB=23, EXP_ALL_ONES=8'hFF, MANT_WIDTH=23, and the zero word constant.
REQ-023 A combinational sub-module relu_fp32 (one lane, DATA_WIDTH in/out) SHALL be instantiated OUTPUT_NODES times via generate.
REQ-024 The top level SHALL own the output register bank, reset and enable logic.

Verification
REQ-025 All lanes 0x80000000, reset=1 for one cycle → output_fc all zero; then reset=0, en=1, same input → all lanes 0x00000000 after one edge.
REQ-026 Lane 31 = 0x40000000 (2.0), lane 30 = 0x80000000, other lanes 0x40000000, en=1 → lane 30 = 0x00000000, all others 0x40000000 one edge later.
REQ-027 Captured 0x40000000 in all lanes, then input all 0xBF800000 (-1.0) with en=0 → output holds 0x40000000; raising en=1 → zeros after one edge.
REQ-028 Lanes 0x7F800000, 0xFF800000, 0x00000001, 0x7FC00000 → outputs 0x7F800000, 0x00000000, 0x00000001, and 0x7FC00000 (0x00000000 with ACT_NAN_FLUSH_EN).
REQ-029 Reset and en both 1 with input all 0x3F800000 → output all zero; next edge with reset=0 → all 0x3F800000.

Source files
------------

// File: rtl/activation_function_pkg.sv
// Shared FP32 field layout for the ReLU activation datapath.
// Optional build macro: ACT_NAN_FLUSH_EN (flush positive NaN lanes to +0.0).
package activation_function_pkg;

  localparam int          SIGN_BIT     = 31;
  localparam int          EXP_MSB      = 30;
  localparam int          EXP_LSB      = 23;
  localparam logic [7:0]  EXP_ALL_ONES = 8'hFF;
  localparam int          MANT_WIDTH   = 23;
  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;

  typedef logic [31:0] fp32_t;

  // True for any NaN encoding, irrespective of sign.
  function automatic logic fp32_is_nan(input fp32_t word);
    return (word[EXP_MSB:EXP_LSB] == EXP_ALL_ONES) && (word[MANT_WIDTH-1:0] != '0);
  endfunction

endpackage

// File: rtl/activation_function_if.sv
// Bundles the capture-enable and packed lane buses of the activation block.
// Used by benches to drive and observe activation_function.
interface activation_function_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int OUTPUT_NODES = 32
);
  logic                                 en;
  logic [DATA_WIDTH*OUTPUT_NODES-1:0]   input_fc;
  logic [DATA_WIDTH*OUTPUT_NODES-1:0]   output_fc;

  modport master (output en, output input_fc, input output_fc);
  modport slave  (input en, input input_fc, output output_fc);
endinterface

// File: rtl/activation_function_relu_fp32.sv
// Combinational single-lane FP32 ReLU; negative words (incl. -0, -inf, -NaN) become +0.0.
// With ACT_NAN_FLUSH_EN defined, positive NaN is also flushed to +0.0.
module relu_fp32
  import activation_function_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  always_comb begin
    data_o = data_i;
    if (data_i[DATA_WIDTH-1]) begin
      data_o = '0;
    end
`ifdef ACT_NAN_FLUSH_EN
    if (fp32_is_nan(fp32_t'(data_i))) begin
      data_o = '0;
    end
`else
`endif
  end

endmodule

// File: rtl/activation_function.sv
// Registered multi-lane FP32 ReLU: one-clock latency, enable-gated capture, sync reset.
// Optional build macro: ACT_NAN_FLUSH_EN (handled inside relu_fp32).
module activation_function
  import activation_function_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int OUTPUT_NODES = 32
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               en,
  input  logic [DATA_WIDTH*OUTPUT_NODES-1:0] input_fc,
  output logic [DATA_WIDTH*OUTPUT_NODES-1:0] output_fc
);

  logic [DATA_WIDTH*OUTPUT_NODES-1:0] output_d;
  logic [DATA_WIDTH*OUTPUT_NODES-1:0] output_q;

  generate
    for (genvar gi = 0; gi < OUTPUT_NODES; gi++) begin : g_lane
      relu_fp32 #(
        .DATA_WIDTH(DATA_WIDTH)
      ) u_relu (
        .data_i(input_fc[DATA_WIDTH*gi +: DATA_WIDTH]),
        .data_o(output_d[DATA_WIDTH*gi +: DATA_WIDTH])
      );
    end
  endgenerate

  // Reset wins over en, so a capture in a reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      output_q <= '0;
    end else if (en) begin
      output_q <= output_d;
    end
  end

  assign output_fc = output_q;

endmodule

// File: tb/tb_activation_function.sv
// Directed self-checking bench for activation_function (honours ACT_NAN_FLUSH_EN).
module tb_activation_function;
  localparam int DW = 32;
  localparam int N  = 32;
  localparam int W  = DW * N;

  logic clk;
  logic reset;
  int   check_cnt;
  int   pass_cnt;

  activation_function_if #(.DATA_WIDTH(DW), .OUTPUT_NODES(N)) af_if ();

  activation_function #(
    .DATA_WIDTH(DW),
    .OUTPUT_NODES(N)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (af_if.en),
    .input_fc (af_if.input_fc),
    .output_fc(af_if.output_fc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] fill(input logic [31:0] word);
    logic [W-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = word;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] expected);
    logic [W-1:0] observed;
    int lane;
    observed = af_if.output_fc;
    lane = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (observed[i*DW +: DW] !== expected[i*DW +: DW]) lane = i;
    end
    check_cnt++;
    assert (observed === expected) pass_cnt++;
    else $error("FAIL %s lane %0d observed %h expected %h", tag, lane,
                observed[lane*DW +: DW], expected[lane*DW +: DW]);
  endtask

  logic [W-1:0] vec;
  logic [W-1:0] exp_vec;
  logic [31:0]  nan_exp;

  initial begin
    check_cnt = 0;
    pass_cnt  = 0;

    // Reset with all lanes negative zero
    reset = 1'b1;
    af_if.en = 1'b0;
    af_if.input_fc = fill(32'h8000_0000);
    tick();
    check("reset_clear", '0);

    reset = 1'b0;
    af_if.en = 1'b1;
    tick();
    check("neg_zero_all", '0);

    // Lane 30 negative zero, others 2.0
    vec = fill(32'h4000_0000);
    vec[30*DW +: DW] = 32'h8000_0000;
    af_if.input_fc = vec;
    exp_vec = fill(32'h4000_0000);
    exp_vec[30*DW +: DW] = 32'h0000_0000;
    tick();
    check("lane30_negzero", exp_vec);

    // Hold with en=0
    af_if.input_fc = fill(32'h4000_0000);
    tick();
    check("capture_two", fill(32'h4000_0000));
    af_if.en = 1'b0;
    af_if.input_fc = fill(32'hBF80_0000);
    tick();
    check("hold_1", fill(32'h4000_0000));
    tick();
    check("hold_2", fill(32'h4000_0000));
    af_if.en = 1'b1;
    tick();
    check("neg_one_zero", '0);

    // Special encodings
`ifdef ACT_NAN_FLUSH_EN
    nan_exp = 32'h0000_0000;
`else
    nan_exp = 32'h7FC0_0000;
`endif
    vec = fill(32'h3F80_0000);
    exp_vec = fill(32'h3F80_0000);
    vec[0*DW +: DW] = 32'h7F80_0000; exp_vec[0*DW +: DW] = 32'h7F80_0000;
    vec[1*DW +: DW] = 32'hFF80_0000; exp_vec[1*DW +: DW] = 32'h0000_0000;
    vec[2*DW +: DW] = 32'h0000_0001; exp_vec[2*DW +: DW] = 32'h0000_0001;
    vec[3*DW +: DW] = 32'h7FC0_0000; exp_vec[3*DW +: DW] = nan_exp;
    vec[4*DW +: DW] = 32'hFFC0_0000; exp_vec[4*DW +: DW] = 32'h0000_0000;
    vec[5*DW +: DW] = 32'h007F_FFFF; exp_vec[5*DW +: DW] = 32'h007F_FFFF;
    vec[6*DW +: DW] = 32'h0000_0000; exp_vec[6*DW +: DW] = 32'h0000_0000;
    vec[7*DW +: DW] = 32'h8000_0001; exp_vec[7*DW +: DW] = 32'h0000_0000;
    vec[8*DW +: DW] = 32'h7F80_0001; exp_vec[8*DW +: DW] = nan_exp == 32'h0 ? 32'h0 : 32'h7F80_0001;
    af_if.input_fc = vec;
    tick();
    check("special_values", exp_vec);

    // Independent lanes: odd lanes negative, even lanes positive
    for (int i = 0; i < N; i++) begin
      vec[i*DW +: DW]     = {i[0], 7'h20, i[7:0], 16'h1234};
      exp_vec[i*DW +: DW] = i[0] ? 32'h0 : {1'b0, 7'h20, i[7:0], 16'h1234};
    end
    af_if.input_fc = vec;
    tick();
    check("lane_pattern", exp_vec);

    // Reset and en together
    af_if.input_fc = fill(32'h3F80_0000);
    reset = 1'b1;
    tick();
    check("reset_over_en", '0);
    reset = 1'b0;
    tick();
    check("after_reset_cap", fill(32'h3F80_0000));

    // Mid-stream reset discards that cycle's capture
    af_if.input_fc = fill(32'h4100_0000);
    reset = 1'b1;
    tick();
    check("midstream_reset", '0);
    reset = 1'b0;
    af_if.en = 1'b0;
    tick();
    check("no_stale_capture", '0);
    af_if.en = 1'b1;
    tick();
    check("first_valid_cap", fill(32'h4100_0000));

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
